mem_access_arbiter: RTL and testbench
=====================================

// Module: mem_access_arbiter
// PURPOSE
//   Shares the single-port MEM block between two requesters (req0, req1).
//   Sequences each access: drives mem_read_ctrl / mem_write_ctrl / mem_address /
//   mem_data_write for exactly one cycle, waits the read latency, returns data.
//   Round-robin arbitration, one access in flight at a time. Sits between the
//   requesters and MEM.
// PARAMETERS
//   AW      3   address width (matches MEM mem_address)
//   DW      3   data width (matches MEM mem_data_write / mem_data_read)
//   RD_LAT  1   cycles from the mem_read_ctrl cycle to valid mem_data_read (>=1)
// PORTS
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous reset, active high
//   req0 / req1     in   1   access request (level)
//   we0 / we1       in   1   1 = write, 0 = read; sampled with address/data
//   addr0 / addr1   in   AW  access address
//   wdata0 / wdata1 in   DW  write data
//   gnt0 / gnt1     out  1   1-cycle pulse: request accepted, operands latched
//   done0 / done1   out  1   1-cycle pulse: access complete; rdata valid if read
//   rdata0 / rdata1 out  DW  read data; held until the next read by that requester
//   mem_read_ctrl   out  1   to MEM
//   mem_write_ctrl  out  1   to MEM
//   mem_address     out  AW  to MEM
//   mem_data_write  out  DW  to MEM
//   mem_data_read   in   DW  from MEM
// BEHAVIOUR
//   - Every output is registered. Reset: all outputs 0, state IDLE, last_served=1
//     (req0 wins the first tie). Reset mid-access abandons it: mem ctrls are 0
//     on the next cycle, no done pulse, rdata cleared.
//   - FSM states:
//     IDLE: if any reqi, pick a winner, latch its we/addr/wdata, go to ISSUE.
//       Next cycle: gnt_winner=1 and mem_*_ctrl are driven.
//     ISSUE: one cycle, mem_write_ctrl=we, mem_read_ctrl=!we, with latched addr
//       and data. Write goes to RESP. Read loads cnt=RD_LAT-1 and goes to WAIT.
//     WAIT: ctrls 0, address held. When cnt==0, capture mem_data_read into
//       rdata_winner and go to RESP; otherwise decrement cnt.
//     RESP: done_winner=1 for one cycle, last_served=winner, go to IDLE.
//   - Arbitration: only one req high -> it wins. Both high -> the requester
//     != last_served wins. The loser keeps req high and is served next.
//   - Handshake: the requester holds req, we, addr and wdata stable until it sees
//     gnt. It must drop req on the cycle after gnt, or a new access is issued.
//     req is ignored outside IDLE. Operand changes after gnt have no effect.
//   - Latency, with the req sampled in IDLE at cycle T:
//     write: gnt and mem_write_ctrl at T+1, done at T+2.
//     read: gnt and mem_read_ctrl at T+1, capture at T+1+RD_LAT,
//       done and rdata at T+2+RD_LAT.
//   - mem_read_ctrl and mem_write_ctrl are never 1 together; each is high at most
//     one cycle per access. No back-to-back issue: there are at least 2 cycles
//     between ISSUE cycles.
//   - done and gnt are never high for both requesters in the same cycle.
//   - Address and data are passed through unmodified (no width conversion).
// TESTING
//   1. rst=1 for 2 clk with req0=req1=1 -> all outputs 0; after release, req0
//      is served first.
//   2. req0 write addr=0 wdata=3'b010 at T -> mem_write_ctrl=1, mem_address=0,
//      mem_data_write=010 at T+1; done0 at T+2.
//   3. req1 write addr=1 wdata=3'b101, then req1 read addr=1 -> done1 with
//      rdata1=101 at T+2+RD_LAT. Repeat with RD_LAT=3.
//   4. req0 and req1 reads both high, held -> grant order 0,1,0,1. Ctrls are
//      never both 1, and no two ISSUE cycles are closer than 3 cycles apart.
//   5. rst asserted during WAIT of a read -> next cycle ctrls 0, no done0,
//      rdata0=0, state IDLE.
//   6. addr0 changed on the cycle after gnt0 (read addr=0, mem[0]=010) ->
//      rdata0=010 from the original address.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//   Shares one single-port memory between two requesters. Only one access is
//   in flight at a time. Each access drives the memory strobe for exactly one
//   cycle. A read then waits RD_LAT cycles, captures the read data and reports
//   completion with a done pulse. Ties between the requesters are broken
//   round-robin.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req0/1, we0/1            request level and write(1)/read(0) select
//   addr0/1, wdata0/1        operands, sampled when the request is accepted
//   gnt0/1                   1-cycle pulse: request accepted, operands latched
//   done0/1                  1-cycle pulse: access complete, rdata valid on read
//   rdata0/1                 last read data per requester, held until next read
//   mem_read_ctrl            read strobe to memory
//   mem_write_ctrl           write strobe to memory
//   mem_address              address to memory
//   mem_data_write           write data to memory
//   mem_data_read            read data from memory
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
    parameter int AW     = 3,
    parameter int DW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_read_ctrl,
    output logic          mem_write_ctrl,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_write,
    input  logic [DW-1:0] mem_data_read
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state_reg, state_next;
    logic          winner_reg, winner_next;
    logic          last_reg, last_next;
    logic          we_reg, we_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    gnt_reg, gnt_next;
    logic [1:0]    done_reg, done_next;
    logic          rd_reg, rd_next;
    logic          wr_reg, wr_next;
    logic          capture;

    // Outputs are computed one state ahead so that every port comes straight
    // from a flop: the strobes and gnt are loaded on the edge that enters
    // ISSUE, done is loaded on the edge that enters RESP.
    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        last_next   = last_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        cnt_next    = cnt_reg;
        gnt_next    = 2'b00;
        done_next   = 2'b00;
        rd_next     = 1'b0;
        wr_next     = 1'b0;
        capture     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    // Single request wins outright; on a tie the requester
                    // that was not served last wins.
                    winner_next = (req0 && req1) ? ~last_reg : req1;
                    we_next     = winner_next ? we1    : we0;
                    addr_next   = winner_next ? addr1  : addr0;
                    wdata_next  = winner_next ? wdata1 : wdata0;
                    gnt_next    = winner_next ? 2'b10  : 2'b01;
                    wr_next     = we_next;
                    rd_next     = ~we_next;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    done_next  = winner_reg ? 2'b10 : 2'b01;
                    state_next = RESP;
                end else begin
                    cnt_next   = CW'(RD_LAT - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    done_next  = winner_reg ? 2'b10 : 2'b01;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RESP: begin
                last_next  = winner_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            winner_reg <= 1'b0;
            last_reg   <= 1'b1;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            gnt_reg    <= 2'b00;
            done_reg   <= 2'b00;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            last_reg   <= last_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            cnt_reg    <= cnt_next;
            gnt_reg    <= gnt_next;
            done_reg   <= done_next;
            rd_reg     <= rd_next;
            wr_reg     <= wr_next;
        end
    end

    // Per-requester read data holding registers; only the current winner's
    // register is loaded, so the other requester's last result is kept.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            logic [DW-1:0] rdata_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (capture && (winner_reg == 1'(gi))) begin
                    rdata_reg <= mem_data_read;
                end
            end
        end
    endgenerate

    assign gnt0           = gnt_reg[0];
    assign gnt1           = gnt_reg[1];
    assign done0          = done_reg[0];
    assign done1          = done_reg[1];
    assign rdata0         = g_rdata[0].rdata_reg;
    assign rdata1         = g_rdata[1].rdata_reg;
    assign mem_read_ctrl  = rd_reg;
    assign mem_write_ctrl = wr_reg;
    assign mem_address    = addr_reg;
    assign mem_data_write = wdata_reg;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_access_arbiter
//   Drives the arbiter from two requester tasks, models the memory with a
//   RD_LAT-deep read pipeline, and checks every access against a reference
//   memory array, expected per-requester read data and round-robin order.
// -----------------------------------------------------------------------------
module tb_mem_access_arbiter;

    localparam int AW     = 3;
    localparam int DW     = 3;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [1:0]    we  = 2'b00;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [DW-1:0] rdata [2];
    logic          mem_read_ctrl;
    logic          mem_write_ctrl;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic [DW-1:0] mem_data_read;

    always #5 clk = ~clk;

    mem_access_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req[0]),
        .req1          (req[1]),
        .we0           (we[0]),
        .we1           (we[1]),
        .addr0         (addr[0]),
        .addr1         (addr[1]),
        .wdata0        (wdata[0]),
        .wdata1        (wdata[1]),
        .gnt0          (gnt[0]),
        .gnt1          (gnt[1]),
        .done0         (done[0]),
        .done1         (done[1]),
        .rdata0        (rdata[0]),
        .rdata1        (rdata[1]),
        .mem_read_ctrl (mem_read_ctrl),
        .mem_write_ctrl(mem_write_ctrl),
        .mem_address   (mem_address),
        .mem_data_write(mem_data_write),
        .mem_data_read (mem_data_read)
    );

    // Memory: data for a read strobe appears RD_LAT cycles later; otherwise
    // the read bus carries junk so a mistimed capture shows up.
    logic [DW-1:0] mem_array [2**AW] = '{default: '0};
    logic [DW-1:0] rd_pipe [RD_LAT]  = '{default: '0};
    always @(posedge clk) begin
        if (mem_write_ctrl) mem_array[mem_address] <= mem_data_write;
        rd_pipe[0] <= mem_read_ctrl ? mem_array[mem_address] : DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_read = rd_pipe[RD_LAT-1];

    // Reference model state
    logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
    logic [DW-1:0] exp_rdata [2]   = '{default: '0};
    int            model_last = 1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle monitor, sampled just after the active edge.
    int last_issue = -100;
    int gq[$];
    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("rst_outputs", {gnt, done, mem_read_ctrl, mem_write_ctrl, rdata[0], rdata[1],
                                  mem_address, mem_data_write}, 0);
            last_issue = -100;
        end else begin
            check("ctrl_exclusive", 32'(mem_read_ctrl & mem_write_ctrl), 0);
            check("gnt_exclusive", 32'(gnt == 2'b11), 0);
            check("done_exclusive", 32'(done == 2'b11), 0);
            if (mem_read_ctrl || mem_write_ctrl) begin
                check("issue_gap", 32'((cyc - last_issue) >= 3), 1);
                last_issue = cyc;
            end
            if (gnt[0]) gq.push_back(0);
            if (gnt[1]) gq.push_back(1);
        end
    end

    // One access by requester `who`. `first` means the arbiter is known to be
    // idle and this requester wins, so grant latency is checked. `mangle`
    // scrambles the operands right after the grant.
    task automatic access(input int who, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit first, input bit mangle);
        int            t0, tg;
        bit            seen;
        logic [DW-1:0] exp_val;
        exp_val = '0;
        @(negedge clk);
        req[who] = 1'b1; we[who] = w; addr[who] = a; wdata[who] = d;
        t0 = cyc;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (gnt[who]) seen = 1;
        end
        check($sformatf("gnt%0d_seen", who), 32'(seen), 1);
        if (!seen) begin
            req[who] = 1'b0;
            return;
        end
        tg = cyc;
        if (first) check($sformatf("gnt%0d_latency", who), tg - t0, 1);
        check($sformatf("issue%0d_ctrl", who), {mem_write_ctrl, mem_read_ctrl}, w ? 2 : 1);
        check($sformatf("issue%0d_addr", who), mem_address, a);
        if (w) begin
            check($sformatf("issue%0d_wdata", who), mem_data_write, d);
            ref_mem[a] = d;
        end else begin
            exp_val = ref_mem[a];
        end
        req[who] = 1'b0;
        if (mangle) begin
            addr[who] = ~a; wdata[who] = ~d; we[who] = ~w;
        end
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done[who]) seen = 1;
        end
        check($sformatf("done%0d_seen", who), 32'(seen), 1);
        if (!seen) return;
        check($sformatf("done%0d_latency", who), cyc - tg, w ? 1 : 1 + RD_LAT);
        if (!w) exp_rdata[who] = exp_val;
        check($sformatf("rdata%0d", who), rdata[who], exp_rdata[who]);
        check($sformatf("rdata%0d_held", 1 - who), rdata[1-who], exp_rdata[1-who]);
        model_last = who;
    endtask

    // Both requesters raise req together; winner is the one not served last.
    task automatic pair(input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int f;
        f = 1 - model_last;
        gq.delete();
        fork
            access(0, w0, a0, d0, f == 0, 0);
            access(1, w1, a1, d1, f == 1, 0);
        join
        check("order_count", gq.size(), 2);
        if (gq.size() == 2) begin
            check("order_first", gq[0], f);
            check("order_second", gq[1], 1 - f);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        // Reset held with both requests high.
        rst = 1'b1; req = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0; req = 2'b00;

        // req0 wins the first tie after reset.
        pair(0, 0, 0, 0, 0, 0);

        // Single write by req0.
        access(0, 1, 3'd0, 3'b010, 1, 0);

        // req1 write then read back.
        access(1, 1, 3'd1, 3'b101, 1, 0);
        access(1, 0, 3'd1, 3'd0, 1, 0);

        // Held reads from both: alternating grants.
        pair(0, 3'd1, 0, 0, 3'd0, 0);
        pair(0, 3'd0, 0, 0, 3'd1, 0);

        // Operands scrambled after grant do not affect the access.
        access(0, 0, 3'd0, 3'd0, 1, 1);

        // Reset in the wait phase of a read abandons it.
        access(0, 0, 3'd1, 3'd0, 1, 0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd1;
        @(negedge clk);
        check("abandon_gnt0", 32'(gnt[0]), 1);
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abandon_ctrls", {mem_read_ctrl, mem_write_ctrl}, 0);
        check("abandon_done0", 32'(done[0]), 0);
        check("abandon_rdata0", rdata[0], 0);
        rst = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; model_last = 1;
        access(1, 1, 3'd2, 3'b011, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: access(0, 1'($urandom), AW'($urandom), DW'($urandom), 1, 1'($urandom));
                1: access(1, 1'($urandom), AW'($urandom), DW'($urandom), 1, 1'($urandom));
                default: pair(1'($urandom), AW'($urandom), DW'($urandom),
                              1'($urandom), AW'($urandom), DW'($urandom));
            endcase
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
